// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin index arbiter.
// The state enum is shared so any future block sees the same FSM encoding.
package arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam int IDX_W_DEF    = 3;
    localparam int N_DEF        = 2 ** IDX_W_DEF;
    localparam int MAX_HOLD_DEF = 16;

    // Hold counter width; never below one bit, even when the timeout is disabled.
    function automatic int hold_w(input int max_hold);
        return ($clog2(max_hold + 1) < 1) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/rr_index_arbiter_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping N-1 -> 0.
// The request vector is rotated right by ptr, the lowest set bit is found, then ptr is added back.
module rr_index_arbiter_pick
    import arb_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int N     = 2 ** IDX_W
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [2*N-1:0]   req_dbl;
    logic [N-1:0]     req_rot;
    logic [IDX_W-1:0] off;

    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[N-1:0];

    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off = IDX_W'(i);
            end
        end
    end

    assign any = |req;
    assign idx = off + ptr;

endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter for 2**IDX_W requesters, emitting a registered winner index.
// gnt_idx is meant to feed a downstream decoder3x8 whose output is gated by gnt_valid.
module rr_index_arbiter
    import arb_pkg::*;
#(
    parameter int IDX_W    = IDX_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [(2**IDX_W)-1:0]   req,
    input  logic                    done,
    output logic [IDX_W-1:0]        gnt_idx,
    output logic                    gnt_valid,
    output logic                    timeout
);

    // state | meaning
    // IDLE  | no grant; arbitrate among req starting at ptr
    // GRANT | gnt_idx owns the resource until done, request drop or hold timeout

    localparam int N    = 2 ** IDX_W;
    localparam int HC_W = hold_w(MAX_HOLD);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [HC_W-1:0]  hold_q, hold_d;
    logic [IDX_W-1:0] idx_d;
    logic             valid_d;
    logic             timeout_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             owner_rel;
    logic             hold_hit;

    rr_index_arbiter_pick #(
        .IDX_W (IDX_W),
        .N     (N)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign owner_rel = done || !req[gnt_idx];
    assign hold_hit  = (MAX_HOLD != 0) && (hold_q == HC_W'(MAX_HOLD - 1));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        idx_d     = gnt_idx;
        valid_d   = gnt_valid;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    idx_d   = pick_idx;
                    valid_d = 1'b1;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (owner_rel || hold_hit) begin
                    valid_d   = 1'b0;
                    ptr_d     = gnt_idx + IDX_W'(1);
                    state_d   = IDLE;
                    // timeout only flags a release the owner did not ask for
                    timeout_d = hold_hit && !owner_rel;
                end else if (MAX_HOLD != 0) begin
                    hold_d = hold_q + HC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt_idx   <= idx_d;
            gnt_valid <= valid_d;
            timeout   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Directed bench for rr_index_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_rr_index_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    rr_index_arbiter #(
        .IDX_W    (3),
        .MAX_HOLD (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        cyc();
        cyc();
        chk("rst_valid", 32'(gnt_valid), 32'd0);
        chk("rst_idx", 32'(gnt_idx), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("idle_no_req", 32'(gnt_valid), 32'd0);

        // single request, then done moves ptr to 5
        req = 8'h10;
        cyc();
        chk("single_valid", 32'(gnt_valid), 32'd1);
        chk("single_idx", 32'(gnt_idx), 32'd4);
        done = 1'b1;
        cyc();
        done = 1'b0;
        req  = 8'h30;
        chk("done_release", 32'(gnt_valid), 32'd0);
        chk("idx_retained", 32'(gnt_idx), 32'd4);
        cyc();
        chk("ptr5_idx", 32'(gnt_idx), 32'd5);
        chk("ptr5_valid", 32'(gnt_valid), 32'd1);
        req = 8'h00;
        cyc();
        chk("drop_release5", 32'(gnt_valid), 32'd0);

        // drive ptr to 7, then check wrap
        req = 8'h40;
        cyc();
        chk("grant6", 32'(gnt_idx), 32'd6);
        req = 8'h00;
        cyc();
        req = 8'h81;
        cyc();
        chk("wrap_idx7", 32'(gnt_idx), 32'd7);
        chk("wrap_valid7", 32'(gnt_valid), 32'd1);
        done = 1'b1;
        cyc();
        done = 1'b0;
        chk("wrap_release", 32'(gnt_valid), 32'd0);
        cyc();
        chk("wrap_idx0", 32'(gnt_idx), 32'd0);
        chk("wrap_valid0", 32'(gnt_valid), 32'd1);
        req = 8'h00;
        cyc();

        // async reset in the middle of a grant to 5
        req = 8'h20;
        cyc();
        chk("pre_rst_idx5", 32'(gnt_idx), 32'd5);
        chk("pre_rst_valid", 32'(gnt_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(gnt_valid), 32'd0);
        chk("midrst_timeout", 32'(timeout), 32'd0);
        chk("midrst_idx", 32'(gnt_idx), 32'd0);
        req = 8'h00;
        cyc();
        rst_n = 1'b1;
        cyc();

        // round robin with all requesters, done on every third grant cycle
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            cyc();
            chk("rr_valid", 32'(gnt_valid), 32'd1);
            chk("rr_idx", 32'(gnt_idx), 32'(g % 8));
            cyc();
            chk("rr_hold", 32'(gnt_idx), 32'(g % 8));
            done = 1'b1;
            cyc();
            done = 1'b0;
            chk("rr_gap", 32'(gnt_valid), 32'd0);
        end
        req = 8'h00;
        cyc();
        chk("rr_end_idle", 32'(gnt_valid), 32'd0);

        // done while idle has no effect
        done = 1'b1;
        cyc();
        done = 1'b0;
        chk("idle_done", 32'(gnt_valid), 32'd0);
        chk("idle_done_to", 32'(timeout), 32'd0);

        // hold timeout: ptr is 1, so req 04 wins as index 2
        req = 8'h04;
        cyc();
        for (int i = 0; i < 16; i++) begin
            chk("to_hold_valid", 32'(gnt_valid), 32'd1);
            chk("to_hold_pulse", 32'(timeout), 32'd0);
            cyc();
        end
        chk("to_released", 32'(gnt_valid), 32'd0);
        chk("to_pulse", 32'(timeout), 32'd1);
        cyc();
        chk("to_regrant_valid", 32'(gnt_valid), 32'd1);
        chk("to_regrant_idx", 32'(gnt_idx), 32'd2);
        chk("to_pulse_cleared", 32'(timeout), 32'd0);

        // request drop releases on the same edge
        req = 8'h08;
        cyc();
        chk("drop2_release", 32'(gnt_valid), 32'd0);
        cyc();
        chk("grant3_idx", 32'(gnt_idx), 32'd3);
        chk("grant3_valid", 32'(gnt_valid), 32'd1);
        for (int i = 0; i < 15; i++) begin
            cyc();
        end
        chk("grant3_still", 32'(gnt_valid), 32'd1);
        req  = 8'h00;
        done = 1'b1;
        cyc();
        done = 1'b0;
        chk("coinc_release", 32'(gnt_valid), 32'd0);
        chk("coinc_no_to", 32'(timeout), 32'd0);
        cyc();
        chk("coinc_idle", 32'(gnt_valid), 32'd0);
        chk("coinc_no_to2", 32'(timeout), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
